hc_dec: RTL and testbench

Pipelined Hamming(7,4) single-error-correcting decoder, the receive-side counterpart of `hc_enc`. It accepts 7-bit codewords in `hc_enc` bit order over a valid/ready stream and computes the 3-bit syndrome. It corrects any single flipped bit, then returns the 4 data bits with error status. Saturating statistics counters track decoded and corrected words for the link monitor.

---
 rtl/hc_dec.sv | 156 +++++++++++++++
 tb/tb_hc_dec.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_dec.sv
// hc_dec: pipelined Hamming(7,4) single-error-correcting decoder.
//
// Stage 1 registers the incoming codeword together with its 3-bit syndrome.
// Stage 2 flips the bit addressed by the syndrome, extracts the four data
// bits and presents them with the error flag and syndrome. A single global
// enable freezes both stages while the output is held by backpressure.
// Two saturating counters record decoded and corrected words.

module hc_dec #(
    parameter int CNT_WD = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:1]        i_enc_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [4:1]        o_data,
    output logic              o_err,
    output logic [3:1]        o_syn,
    input  logic              i_clr_cnt,
    output logic [CNT_WD-1:0] o_word_cnt,
    output logic [CNT_WD-1:0] o_corr_cnt
);

    localparam logic [CNT_WD-1:0] CNT_MAX = '1;
    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

    // Syndrome {s4,s2,s1}: each parity check covers the positions whose
    // index has the matching bit set, so the result names the bad position.
    function automatic logic [3:1] calc_syn(input logic [7:1] c);
        logic [3:1] s;
        s[1] = c[1] ^ c[3] ^ c[5] ^ c[7];
        s[2] = c[2] ^ c[3] ^ c[6] ^ c[7];
        s[3] = c[4] ^ c[5] ^ c[6] ^ c[7];
        return s;
    endfunction

    // Pipeline advance and handshake
    logic             w_en;
    logic             w_load;

    // Stage 1
    logic             r_s1_valid;
    logic [7:1]       r_s1_code;
    logic [3:1]       r_s1_syn;
    logic [3:1]       w_in_syn;

    // Correction datapath between the stages
    logic [7:1]       w_flip;
    logic [7:1]       w_fixed;
    logic [4:1]       w_data;
    logic             w_err;

    // Output stage
    logic             r_o_valid;
    logic [4:1]       r_o_data;
    logic             r_o_err;
    logic [3:1]       r_o_syn;

    // Statistics
    logic [CNT_WD-1:0] r_word_cnt;
    logic [CNT_WD-1:0] r_corr_cnt;

    // The whole pipeline moves whenever the output slot is empty or drained.
    assign w_en    = !r_o_valid || i_ready;
    assign o_ready = w_en;

    // A word enters the output register on this edge.
    assign w_load  = w_en && r_s1_valid;

    // Syndrome of the incoming codeword, registered alongside it in stage 1.
    always_comb begin
        w_in_syn = calc_syn(i_enc_data);
    end

    // Stage 1 valid flag: advances with the pipeline, cleared by reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values, independent of statement order.
        if (i_rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
        end
    end

    // Stage 1 payload: captured only when a codeword is actually accepted.
    always_ff @(posedge i_clk) begin
        // NOTE: the payload has no reset; r_s1_valid alone qualifies it, and
        // leaving it unreset keeps the datapath flops free of a reset tree.
        if (w_en && i_valid) begin
            r_s1_code <= i_enc_data;
            r_s1_syn  <= w_in_syn;
        end
    end

    // Flip the bit the syndrome points at, then pull out the data positions.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        w_flip = '0;
        for (int p = 1; p <= 7; p++) begin
            if (r_s1_syn == 3'(p)) begin
                w_flip[p] = 1'b1;
            end
        end
        w_fixed = r_s1_code ^ w_flip;
        w_data  = {w_fixed[7], w_fixed[6], w_fixed[5], w_fixed[3]};
        w_err   = |r_s1_syn;
    end

    // Output stage: valid follows stage 1, fields load only with a real word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_err   <= 1'b0;
            r_o_syn   <= '0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o_data <= w_data;
                r_o_err  <= w_err;
                r_o_syn  <= r_s1_syn;
            end
        end
    end

    // Decoded-word counter: clear wins over a same-cycle load, then saturate.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_word_cnt <= '0;
        end else if (w_load && (r_word_cnt != CNT_MAX)) begin
            r_word_cnt <= r_word_cnt + CNT_ONE;
        end
    end

    // Corrected-word counter: same rules, counting only non-zero syndromes.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_corr_cnt <= '0;
        end else if (w_load && w_err && (r_corr_cnt != CNT_MAX)) begin
            r_corr_cnt <= r_corr_cnt + CNT_ONE;
        end
    end

    assign o_valid    = r_o_valid;
    assign o_data     = r_o_data;
    assign o_err      = r_o_err;
    assign o_syn      = r_o_syn;
    assign o_word_cnt = r_word_cnt;
    assign o_corr_cnt = r_corr_cnt;

endmodule

// File: tb/tb_hc_dec.sv
// tb_hc_dec: self-checking bench for the Hamming(7,4) decoder.
// Two instances share all inputs; the second has 3-bit counters so that
// saturation is exercised alongside the default-width counters.

module tb_hc_dec;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_ready;
    logic        i_clr_cnt;
    logic [7:1]  i_enc_data;

    logic        o_ready, o_valid, o_err;
    logic [4:1]  o_data;
    logic [3:1]  o_syn;
    logic [15:0] o_word_cnt, o_corr_cnt;

    logic        s_ready, s_valid, s_err;
    logic [4:1]  s_data;
    logic [3:1]  s_syn;
    logic [2:0]  s_word_cnt, s_corr_cnt;

    hc_dec #(.CNT_WD(16)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_enc_data(i_enc_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_err(o_err), .o_syn(o_syn), .i_clr_cnt(i_clr_cnt),
        .o_word_cnt(o_word_cnt), .o_corr_cnt(o_corr_cnt)
    );

    hc_dec #(.CNT_WD(3)) u_dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_enc_data(i_enc_data), .o_valid(s_valid), .i_ready(i_ready),
        .o_data(s_data), .o_err(s_err), .o_syn(s_syn), .i_clr_cnt(i_clr_cnt),
        .o_word_cnt(s_word_cnt), .o_corr_cnt(s_corr_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } res_t;

    typedef struct {
        string      name;
        logic [7:1] code;
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   sb_en = 1'b0;
    bit   last_in_hs = 1'b0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    int   m_words = 0;
    int   m_corr = 0;
    res_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference encoder: data in positions 3,5,6,7; the parity bit at
    // position 2^k covers every other position whose index has bit k set.
    function automatic logic [7:1] ref_encode(input logic [3:0] d);
        logic [7:1] cw;
        logic       par;
        cw    = '0;
        cw[3] = d[0];
        cw[5] = d[1];
        cw[6] = d[2];
        cw[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                if (((j >> k) & 1) == 1 && j != (1 << k)) par ^= cw[j];
            end
            cw[1 << k] = par;
        end
        return cw;
    endfunction

    // Reference decoder: nearest codeword by exhaustive search. The code is
    // perfect, so exactly one codeword lies within distance 1 of any word.
    function automatic res_t ref_decode(input logic [7:1] c);
        res_t       r;
        logic [7:1] diff;
        r = '0;
        for (int d = 0; d < 16; d++) begin
            diff = ref_encode(4'(d)) ^ c;
            if ($countones(diff) <= 1) begin
                r.data = 4'(d);
                r.err  = (diff != '0);
                r.syn  = '0;
                for (int p = 1; p <= 7; p++) begin
                    if (diff[p]) r.syn = 3'(p);
                end
            end
        end
        return r;
    endfunction

    task automatic check_out();
        res_t e;
        if (q.size() == 0) begin
            check("sb_queue_nonempty", q.size(), 1);
            return;
        end
        e = q.pop_front();
        m_words++;
        if (e.err) m_corr++;
        check("sb_data", o_data, e.data);
        check("sb_err", o_err, e.err);
        check("sb_syn", o_syn, e.syn);
        check("sb_word_cnt", o_word_cnt, sat(m_words, 65535));
        check("sb_corr_cnt", o_corr_cnt, sat(m_corr, 65535));
        check("sb_sat_word_cnt", s_word_cnt, sat(m_words, 7));
        check("sb_sat_corr_cnt", s_corr_cnt, sat(m_corr, 7));
    endtask

    // One clock: let o_ready settle, record handshakes, then cross the edge.
    task automatic step();
        bit in_hs, out_hs;
        #1;
        in_hs  = i_valid && o_ready;
        out_hs = o_valid && i_ready;
        if (in_hs) in_cnt++;
        if (out_hs) out_cnt++;
        if (sb_en) begin
            if (out_hs) check_out();
            if (in_hs) q.push_back(ref_decode(i_enc_data));
        end
        last_in_hs = in_hs;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[9];
        logic [7:1] code;
        logic [7:1] bp[3];
        logic [7:0] snap;
        int         exp_corr;
        int         in0, out0, idx;

        vecs[0] = '{"clean_1011",    7'b1010101, 4'b1011, 1'b0, 3'd0};
        vecs[1] = '{"bit5_1011",     7'b1000101, 4'b1011, 1'b1, 3'd5};
        vecs[2] = '{"clean_zero",    7'b0000000, 4'b0000, 1'b0, 3'd0};
        vecs[3] = '{"clean_ones",    7'b1111111, 4'b1111, 1'b0, 3'd0};
        vecs[4] = '{"parity1_only",  7'b0000001, 4'b0000, 1'b1, 3'd1};
        vecs[5] = '{"bit7_zero",     7'b1000000, 4'b0000, 1'b1, 3'd7};
        vecs[6] = '{"bit3_ones",     7'b1111011, 4'b1111, 1'b1, 3'd3};
        vecs[7] = '{"double_miscor", 7'b0000011, 4'b0001, 1'b1, 3'd3};
        vecs[8] = '{"parity2_1001",  7'b1001110, 4'b1001, 1'b1, 3'd2};

        // Reset state
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_clr_cnt = 1'b0;
        i_enc_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_data", o_data, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_syn", o_syn, 0);
        check("rst_word_cnt", o_word_cnt, 0);
        check("rst_corr_cnt", o_corr_cnt, 0);
        check("rst_sat_word_cnt", s_word_cnt, 0);

        // Directed vector table, one word at a time, with latency checks
        exp_corr = 0;
        i_ready  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            i_valid    = 1'b1;
            i_enc_data = vecs[i].code;
            step();
            check({vecs[i].name, "_latency_not_early"}, o_valid, 0);
            i_valid = 1'b0;
            step();
            if (vecs[i].err) exp_corr++;
            check({vecs[i].name, "_valid"}, o_valid, 1);
            check({vecs[i].name, "_data"}, o_data, vecs[i].data);
            check({vecs[i].name, "_err"}, o_err, vecs[i].err);
            check({vecs[i].name, "_syn"}, o_syn, vecs[i].syn);
            check({vecs[i].name, "_word_cnt"}, o_word_cnt, i + 1);
            check({vecs[i].name, "_corr_cnt"}, o_corr_cnt, exp_corr);
            check({vecs[i].name, "_sat_word_cnt"}, s_word_cnt, sat(i + 1, 7));
            check({vecs[i].name, "_sat_corr_cnt"}, s_corr_cnt, sat(exp_corr, 7));
        end

        // Full sweep streamed back-to-back
        i_clr_cnt = 1'b1; i_valid = 1'b0;
        step();
        i_clr_cnt = 1'b0;
        m_words = 0; m_corr = 0; q.delete();
        sb_en = 1'b1;
        in0 = in_cnt; out0 = out_cnt;
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                code = ref_encode(4'(d));
                if (e != 0) code[e] = ~code[e];
                i_valid    = 1'b1;
                i_enc_data = code;
                step();
            end
        end
        i_valid = 1'b0;
        step();
        step();
        check("sweep_accepted", in_cnt - in0, 128);
        check("sweep_delivered", out_cnt - out0, 128);
        check("sweep_word_cnt", o_word_cnt, 128);
        check("sweep_corr_cnt", o_corr_cnt, 112);
        check("sweep_sat_word_cnt", s_word_cnt, 7);
        check("sweep_sat_corr_cnt", s_corr_cnt, 7);

        // Clear coinciding with a counted load
        sb_en = 1'b0;
        i_valid = 1'b1; i_enc_data = 7'b1000101;
        step();
        i_valid = 1'b0; i_clr_cnt = 1'b1;
        step();
        i_clr_cnt = 1'b0;
        check("clr_hit_valid", o_valid, 1);
        check("clr_hit_data", o_data, 4'b1011);
        check("clr_hit_word_cnt", o_word_cnt, 0);
        check("clr_hit_corr_cnt", o_corr_cnt, 0);
        check("clr_hit_sat_word_cnt", s_word_cnt, 0);
        check("clr_hit_sat_corr_cnt", s_corr_cnt, 0);
        step();
        m_words = 0; m_corr = 0; q.delete();

        // Backpressure: three words offered while the output is stalled
        sb_en = 1'b1;
        bp[0] = ref_encode(4'd5) ^ 7'b0010000;
        bp[1] = ref_encode(4'd12);
        bp[2] = ref_encode(4'd3) ^ 7'b0000010;
        i_ready = 1'b0; idx = 0; out0 = out_cnt; snap = '0;
        for (int c = 0; c < 5; c++) begin
            i_valid    = (idx < 3);
            i_enc_data = (idx < 3) ? bp[idx] : '0;
            step();
            if (last_in_hs) idx++;
            if (c >= 1) begin
                check("bp_ready_low", o_ready, 0);
                if (c == 1) snap = {o_data, o_err, o_syn};
                else check("bp_output_stable", {o_data, o_err, o_syn}, snap);
            end
        end
        check("bp_accepted_during_stall", idx, 2);
        i_ready = 1'b1;
        for (int c = 0; c < 10 && (idx < 3 || q.size() > 0); c++) begin
            i_valid    = (idx < 3);
            i_enc_data = (idx < 3) ? bp[idx] : '0;
            step();
            if (last_in_hs) idx++;
        end
        i_valid = 1'b0;
        check("bp_delivered", out_cnt - out0, 3);
        check("bp_word_cnt", o_word_cnt, 3);
        check("bp_drained", q.size(), 0);

        // Reset with both stages holding words
        sb_en = 1'b0; q.delete();
        i_ready = 1'b0; i_valid = 1'b1;
        i_enc_data = ref_encode(4'd9);
        step();
        i_enc_data = ref_encode(4'd10) ^ 7'b0000100;
        step();
        check("rst_mid_pre_valid", o_valid, 1);
        i_valid = 1'b0; i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("rst_mid_o_valid", o_valid, 0);
        check("rst_mid_o_ready", o_ready, 1);
        check("rst_mid_word_cnt", o_word_cnt, 0);
        check("rst_mid_corr_cnt", o_corr_cnt, 0);
        check("rst_mid_sat_word_cnt", s_word_cnt, 0);
        i_ready = 1'b1; i_valid = 1'b1;
        i_enc_data = ref_encode(4'd6) ^ 7'b0100000;
        step();
        i_valid = 1'b0;
        step();
        check("rst_mid_next_valid", o_valid, 1);
        check("rst_mid_next_data", o_data, 4'd6);
        check("rst_mid_next_err", o_err, 1);
        check("rst_mid_next_syn", o_syn, 6);
        check("rst_mid_next_word_cnt", o_word_cnt, 1);
        check("rst_mid_next_corr_cnt", o_corr_cnt, 1);

        // Randomized traffic with random backpressure against the model
        i_clr_cnt = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        step();
        i_clr_cnt = 1'b0;
        m_words = 0; m_corr = 0; q.delete(); last_in_hs = 1'b0;
        sb_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!i_valid || last_in_hs) begin
                i_valid    = ($urandom_range(0, 3) != 0);
                i_enc_data = 7'($urandom_range(0, 127));
            end
            i_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) step();
        check("rand_drained", q.size(), 0);
        check("rand_final_word_cnt", o_word_cnt, sat(m_words, 65535));
        check("rand_final_sat_corr_cnt", s_corr_cnt, sat(m_corr, 7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
